mux_scanner: RTL and testbench
==============================

# mux_scanner

Parametrised, registered N:1 channel selector with handshake output. It generalises the fixed 8:1 single-bit conditional mux to CHANNELS channels of DATA_W bits. It adds a direct-select mode and an auto-scan mode that sweeps every channel with a programmable settle time. It sits between a bank of sampled sources (switch/sensor lines) and a single downstream consumer that applies back-pressure via ready.

## Interface
- CHANNELS, 8, number of input channels; must be ≥2; need not be a power of 2.
- DATA_W, 1, width of each channel.
- SEL_W, $clog2(CHANNELS), width of select and channel-index signals.
- DWELL, 4, settle cycles per channel in scan mode; must be ≥1.

- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- In  in  CHANNELS*DATA_W  flattened channel bus; channel k occupies In[k*DATA_W +: DATA_W].
- S  in  SEL_W  channel select, used in direct mode only.
- mode  in  1  0 = direct, 1 = scan; sampled only in IDLE.
- start  in  1  single-cycle request to begin a scan sweep.
- Out  out  DATA_W  registered selected data.
- out_ch  out  SEL_W  channel index that Out came from.
- out_valid  out  1  Out/out_ch hold a word not yet accepted.
- out_ready  in  1  consumer accepts when out_valid && out_ready at a clock edge.
- busy  out  1  high in SETTLE and PRESENT.
- done  out  1  one-cycle pulse after the last scan word is accepted.

## Operation
- States: IDLE, SETTLE, PRESENT, DONE.
- Reset: state IDLE; Out=0, out_ch=0, out_valid=0, busy=0, done=0; channel counter and dwell counter = 0. Reset mid-sweep aborts it with no done pulse.
- IDLE, mode=0 (direct): if !out_valid || out_ready, load Out←In[S], out_ch←S, out_valid←1. Otherwise hold.
- Direct mode, S ≥ CHANNELS: Out←0, out_ch←S, out_valid←1.
- IDLE, mode=1 && start: ch←0, dwell←0, out_valid←0, go to SETTLE. Any unaccepted direct word is discarded.
- IDLE, mode=1 && !start: hold outputs. A pending word remains until accepted.
- SETTLE: dwell increments each cycle. When dwell==DWELL-1: Out←In[ch], out_ch←ch, out_valid←1, go to PRESENT.
- PRESENT: hold until out_ready. On acceptance: out_valid←0.
  - If ch==CHANNELS-1, go to DONE.
  - Otherwise ch←ch+1, dwell←0, go to SETTLE.
- DONE: done=1 for exactly this cycle, then go to IDLE.
- start is ignored outside IDLE. mode and S changes are ignored during a sweep.
- In is sampled only at the capture edge. Changes during SETTLE are intentionally absorbed.

## Timing
- Direct mode latency: 1 cycle, from S/In to Out. With out_ready=1, a new word is delivered every cycle.
- Scan mode: start is sampled at edge E0. out_valid for channel 0 rises at edge E_DWELL.
- With out_ready held high, each channel takes DWELL+1 cycles. done is high in the cycle after edge E_{CHANNELS*(DWELL+1)}.
- The next sweep may start in the first IDLE cycle after done.
- Back-pressure stretches only PRESENT. Out, out_ch and out_valid stay stable while out_valid && !out_ready.
- Acceptance and the next capture never overlap in scan mode, so there is at least one bubble cycle per channel.
- Counters wrap only by explicit reset to 0. ch never exceeds CHANNELS-1.

## Structure
- Package mux_scanner_pkg: state enum (IDLE, SETTLE, PRESENT, DONE) and mode constants MODE_DIRECT=0, MODE_SCAN=1.
- Sub-module channel_select: purely combinational CHANNELS:1 mux of DATA_W-bit slices on the flattened bus, outputting 0 for out-of-range select. It is instantiated once, and its select is driven by S in IDLE and by ch otherwise.
- Top level contains only the FSM, the counters and the output register.

## Test plan
- Reset: hold rst for 3 cycles mid-sweep -> all outputs 0, state IDLE, and no done pulse.
- Direct mode, CHANNELS=8, DATA_W=1, In=8'b1000_0000, S stepping 0..7 with ready=1 -> Out=0 for S=0..6 and Out=1 for S=7, each one cycle later with out_ch=S.
- Scan, DATA_W=4, In channel k = k+3, DWELL=4, ready=1 -> eight words 3..10, out_ch 0..7, spaced 5 cycles apart, then done 40 cycles after start.
- Back-pressure: hold ready low for 6 cycles on channel 2 -> Out/out_ch stable, sweep extended by 6 cycles, no word lost or duplicated.
- Edge cases:
  - start pulsed during busy -> ignored, and only one done is produced.
  - CHANNELS=5 in direct mode with S=6 -> Out=0, out_ch=6.
- Mode switch: a pending direct word with ready=0, then mode=1 plus start -> word dropped, and the sweep begins at ch 0.

Source files
------------

// File: rtl/mux_scanner_pkg.sv
// Shared types and constants for the mux_scanner channel selector.
package mux_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/mux_scanner_channel_select.sv
// Combinational CHANNELS:1 selector over a flattened bus; out-of-range select yields zero.
module mux_scanner_channel_select #(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*DATA_W-1:0] in_i,
  input  logic [SEL_W-1:0]           sel_i,
  output logic [DATA_W-1:0]          data_o
);

  always_comb begin
    data_o = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = in_i[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/mux_scanner.sv
// Registered N:1 channel selector with direct-select and auto-scan modes and a
// valid/ready output handshake.
module mux_scanner
  import mux_scanner_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned DATA_W   = 1,
  parameter int unsigned SEL_W    = $clog2(CHANNELS),
  parameter int unsigned DWELL    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS*DATA_W-1:0] In,
  input  logic [SEL_W-1:0]           S,
  input  logic                       mode,
  input  logic                       start,
  output logic [DATA_W-1:0]          Out,
  output logic [SEL_W-1:0]           out_ch,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       done
);

  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  state_e               state_q, state_d;
  logic [SEL_W-1:0]     ch_q, ch_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [DATA_W-1:0]    out_q, out_d;
  logic [SEL_W-1:0]     out_ch_q, out_ch_d;
  logic                 out_valid_q, out_valid_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [SEL_W-1:0]     sel_c;
  logic [DATA_W-1:0]    mux_data_c;

  // The single mux is shared: S drives it while idle, the scan counter otherwise.
  assign sel_c = (state_q == IDLE) ? S : ch_q;

  mux_scanner_channel_select #(
    .CHANNELS (CHANNELS),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W)
  ) u_channel_select (
    .in_i   (In),
    .sel_i  (sel_c),
    .data_o (mux_data_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      dwell_q     <= '0;
      out_q       <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      dwell_q     <= dwell_d;
      out_q       <= out_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    dwell_d     = dwell_q;
    out_d       = out_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (mode == MODE_DIRECT) begin
          if (!out_valid_q || out_ready) begin
            out_d       = mux_data_c;
            out_ch_d    = S;
            out_valid_d = 1'b1;
          end
        end else if (start) begin
          // Any unaccepted direct word is dropped when a sweep begins.
          ch_d        = '0;
          dwell_d     = '0;
          out_valid_d = 1'b0;
          state_d     = SETTLE;
        end else if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
        end
      end

      SETTLE: begin
        if (dwell_q == DWELL_W'(DWELL - 1)) begin
          out_d       = mux_data_c;
          out_ch_d    = ch_q;
          out_valid_d = 1'b1;
          state_d     = PRESENT;
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end

      PRESENT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (ch_q == SEL_W'(CHANNELS - 1)) begin
            state_d = DONE;
          end else begin
            ch_d    = ch_q + 1'b1;
            dwell_d = '0;
            state_d = SETTLE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SETTLE) || (state_d == PRESENT);
    done_d = (state_d == DONE);
  end

  assign Out       = out_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mux_scanner.sv
// Self-checking bench for mux_scanner: randomized direct and scan traffic against a
// schedule-level reference model, on an 8-channel and a 5-channel instance.
module tb_mux_scanner;

  localparam int unsigned CH_A = 8;
  localparam int unsigned W_A  = 4;
  localparam int unsigned DW_A = 4;
  localparam int unsigned SW_A = 3;
  localparam int unsigned CH_B = 5;
  localparam int unsigned W_B  = 4;
  localparam int unsigned DW_B = 2;
  localparam int unsigned SW_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [CH_A*W_A-1:0] in_a;
  logic [SW_A-1:0]     s_a;
  logic                mode_a, start_a, ready_a;
  logic [W_A-1:0]      out_a;
  logic [SW_A-1:0]     ch_a;
  logic                valid_a, busy_a, done_a;

  logic [CH_B*W_B-1:0] in_b;
  logic [SW_B-1:0]     s_b;
  logic                mode_b, start_b, ready_b;
  logic [W_B-1:0]      out_b;
  logic [SW_B-1:0]     ch_b;
  logic                valid_b, busy_b, done_b;

  int n_checks   = 0;
  int n_errors   = 0;
  int done_cnt_a = 0;

  mux_scanner #(.CHANNELS(CH_A), .DATA_W(W_A), .DWELL(DW_A)) u_dut_a (
    .clk(clk), .rst(rst), .In(in_a), .S(s_a), .mode(mode_a), .start(start_a),
    .Out(out_a), .out_ch(ch_a), .out_valid(valid_a), .out_ready(ready_a),
    .busy(busy_a), .done(done_a)
  );

  mux_scanner #(.CHANNELS(CH_B), .DATA_W(W_B), .DWELL(DW_B)) u_dut_b (
    .clk(clk), .rst(rst), .In(in_b), .S(s_b), .mode(mode_b), .start(start_b),
    .Out(out_b), .out_ch(ch_b), .out_valid(valid_b), .out_ready(ready_b),
    .busy(busy_b), .done(done_b)
  );

  always @(posedge clk) if (done_a) done_cnt_a <= done_cnt_a + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W_A-1:0] ref_a(input logic [CH_A*W_A-1:0] bus, input int sel);
    if (sel >= int'(CH_A)) return '0;
    return bus[sel*W_A +: W_A];
  endfunction

  function automatic logic [W_B-1:0] ref_b(input logic [CH_B*W_B-1:0] bus, input int sel);
    if (sel >= int'(CH_B)) return '0;
    return bus[sel*W_B +: W_B];
  endfunction

  // Model: channel k is captured DWELL edges after its predecessor is accepted
  // (DWELL edges after start for channel 0) and is held until ready is seen.
  task automatic sweep_a(input int rdy_ctl, input bit chaos);
    int k = 0;
    int cap = int'(DW_A);
    int e = 0;
    int stalls = 0;
    int d0;
    bit pres = 1'b0;
    bit fin = 1'b0;
    logic [W_A-1:0] exp_w = '0;
    d0 = done_cnt_a;
    mode_a  = 1'b1;
    start_a = 1'b1;
    in_a    = $urandom;
    tick();
    check("sweep_start_valid", 32'(valid_a), 32'd0);
    check("sweep_start_busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    while (!fin && e < 500) begin
      in_a = $urandom;
      case (rdy_ctl)
        0:       ready_a = 1'b1;
        1:       ready_a = 1'($urandom_range(0, 1));
        default: ready_a = !(pres && k == 2 && stalls < 6);
      endcase
      if (chaos) begin
        start_a = 1'($urandom);
        mode_a  = 1'($urandom);
        s_a     = SW_A'($urandom);
      end
      e++;
      if (pres && ready_a) begin
        pres = 1'b0;
        if (k == int'(CH_A) - 1) fin = 1'b1;
        else begin
          k++;
          cap = e + int'(DW_A);
        end
      end else if (pres) begin
        stalls++;
      end else if (e == cap) begin
        pres  = 1'b1;
        exp_w = ref_a(in_a, k);
      end
      tick();
      check("sweep_valid", 32'(valid_a), 32'(pres));
      check("sweep_busy", 32'(busy_a), 32'(!fin));
      check("sweep_done", 32'(done_a), 32'(fin));
      if (pres) begin
        check("sweep_out", 32'(out_a), 32'(exp_w));
        check("sweep_ch", 32'(ch_a), 32'(k));
      end
    end
    check("sweep_finished", 32'(fin), 32'd1);
    check("sweep_len", 32'(e), 32'(int'(CH_A) * (int'(DW_A) + 1) + stalls));
    start_a = 1'b0;
    mode_a  = 1'b1;
    ready_a = 1'b1;
    tick();
    check("post_done_low", 32'(done_a), 32'd0);
    check("post_busy_low", 32'(busy_a), 32'd0);
    check("post_valid_low", 32'(valid_a), 32'd0);
    check("done_pulses", 32'(done_cnt_a - d0), 32'd1);
  endtask

  initial begin
    logic [W_A-1:0]  ew;
    logic [SW_A-1:0] ec;
    bit ev;
    int d0, cnt, nc;
    bit got_done;

    rst = 1'b1;
    in_a = '0; s_a = '0; mode_a = 1'b1; start_a = 1'b0; ready_a = 1'b1;
    in_b = '0; s_b = '0; mode_b = 1'b1; start_b = 1'b0; ready_b = 1'b1;
    repeat (3) tick();
    check("rst_out_a", 32'(out_a), 32'd0);
    check("rst_ch_a", 32'(ch_a), 32'd0);
    check("rst_valid_a", 32'(valid_a), 32'd0);
    check("rst_busy_a", 32'(busy_a), 32'd0);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_valid_b", 32'(valid_b), 32'd0);
    rst = 1'b0;

    // Direct mode: only channel 7 carries a one.
    mode_a = 1'b0;
    in_a   = 32'h1000_0000;
    for (int s = 0; s < int'(CH_A); s++) begin
      s_a = SW_A'(s);
      tick();
      check("dir_step_out", 32'(out_a), (s == 7) ? 32'd1 : 32'd0);
      check("dir_step_ch", 32'(ch_a), 32'(s));
      check("dir_step_valid", 32'(valid_a), 32'd1);
    end

    // Direct mode with random data, select and back-pressure.
    ev = 1'b1; ew = ref_a(in_a, 7); ec = 3'd7;
    for (int i = 0; i < 40; i++) begin
      in_a    = $urandom;
      s_a     = SW_A'($urandom);
      ready_a = 1'($urandom_range(0, 1));
      if (!ev || ready_a) begin
        ew = ref_a(in_a, int'(s_a));
        ec = s_a;
        ev = 1'b1;
      end
      tick();
      check("dir_rand_out", 32'(out_a), 32'(ew));
      check("dir_rand_ch", 32'(ch_a), 32'(ec));
      check("dir_rand_valid", 32'(valid_a), 32'(ev));
    end

    // Pending direct word, then switch to scan: word dropped, sweep from ch 0.
    mode_a = 1'b0; ready_a = 1'b0;
    tick();
    check("pending_valid", 32'(valid_a), 32'd1);
    sweep_a(0, 1'b0);
    sweep_a(2, 1'b0);
    sweep_a(1, 1'b1);
    sweep_a(1, 1'b0);

    // Reset in the middle of a sweep.
    mode_a = 1'b1; start_a = 1'b1; ready_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (12) tick();
    d0 = done_cnt_a;
    rst = 1'b1;
    repeat (3) tick();
    check("midrst_out", 32'(out_a), 32'd0);
    check("midrst_ch", 32'(ch_a), 32'd0);
    check("midrst_valid", 32'(valid_a), 32'd0);
    check("midrst_busy", 32'(busy_a), 32'd0);
    rst = 1'b0;
    repeat (45) tick();
    check("midrst_no_done", 32'(done_cnt_a - d0), 32'd0);
    check("midrst_idle_busy", 32'(busy_a), 32'd0);
    sweep_a(0, 1'b0);

    // Five-channel instance: out-of-range direct selects return zero.
    mode_b = 1'b0; ready_b = 1'b1;
    for (int s = 0; s < 8; s++) begin
      in_b = 20'($urandom);
      s_b  = SW_B'(s);
      tick();
      check("b_dir_out", 32'(out_b), 32'(ref_b(in_b, s)));
      check("b_dir_ch", 32'(ch_b), 32'(s));
    end
    s_b = 3'd6; in_b = 20'hFFFFF;
    tick();
    check("b_s6_out", 32'(out_b), 32'd0);
    check("b_s6_ch", 32'(ch_b), 32'd6);

    // Five-channel sweep with ready held high.
    in_b = 20'($urandom);
    mode_b = 1'b1; start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cnt = 0; nc = 0; got_done = 1'b0;
    while (!got_done && cnt < 100) begin
      tick();
      cnt++;
      if (valid_b) begin
        check("b_scan_ch", 32'(ch_b), 32'(nc));
        check("b_scan_out", 32'(out_b), 32'(ref_b(in_b, nc)));
        nc++;
      end
      if (done_b) got_done = 1'b1;
    end
    check("b_done_time", 32'(cnt), 32'(int'(CH_B) * (int'(DW_B) + 1)));
    check("b_words", 32'(nc), 32'(CH_B));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
